// File: rtl/dtc_link_unpacker.sv
// Splits one DTC link word stream into per-BX events and writes stubs into a
// BX-parity ping-pong stub memory; framing faults raise sticky error flags.
module dtc_link_unpacker #(
  parameter int unsigned DATA_W   = 36,
  parameter int unsigned IDX_W    = 6,
  parameter logic [3:0]  HDR_MARK = 4'hA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [63:0]         in_data,
  output logic                mem_we,
  output logic [IDX_W:0]      mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic                evt_done,
  output logic [2:0]          evt_bx,
  output logic [IDX_W:0]      evt_nstub,
  output logic                err_short,
  output logic                err_trunc,
  output logic                err_orphan
);

  localparam int unsigned CNT_W     = IDX_W + 1;
  localparam int unsigned MAX_STUBS = 1 << IDX_W;

  typedef enum logic {IDLE, DATA} state_t;

  state_t            state;
  logic [2:0]        bx;
  logic [7:0]        nstub;
  logic [7:0]        remaining;
  logic [CNT_W-1:0]  idx;
  logic              pend_valid;
  logic [2:0]        pend_bx;

  logic              is_hdr;
  logic [2:0]        hdr_bx;
  logic [7:0]        hdr_n;
  logic              idx_full;
  logic [CNT_W-1:0]  nstub_sat;
  logic              unused_bits;

  assign is_hdr      = (in_data[63:60] == HDR_MARK);
  assign hdr_bx      = in_data[59:57];
  assign hdr_n       = in_data[56:49];
  assign idx_full    = idx[IDX_W];
  assign nstub_sat   = (nstub > 8'(MAX_STUBS)) ? CNT_W'(MAX_STUBS) : CNT_W'(nstub);
  assign unused_bits = ^in_data[48:DATA_W];

  // Pending zero-count done is emitted first; a new zero-count done landing
  // on a busy done slot is parked in the single-entry holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bx         <= 3'd0;
      nstub      <= 8'd0;
      remaining  <= 8'd0;
      idx        <= '0;
      pend_valid <= 1'b0;
      pend_bx    <= 3'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      evt_done   <= 1'b0;
      evt_bx     <= 3'd0;
      evt_nstub  <= '0;
      err_short  <= 1'b0;
      err_trunc  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      evt_done <= 1'b0;
      if (pend_valid) begin
        evt_done   <= 1'b1;
        evt_bx     <= pend_bx;
        evt_nstub  <= '0;
        pend_valid <= 1'b0;
      end
      if (in_valid) begin
        if (is_hdr) begin
          if (state == DATA) begin
            err_short <= 1'b1;
            evt_done  <= 1'b1;
            evt_bx    <= bx;
            evt_nstub <= idx;
          end
          bx        <= hdr_bx;
          nstub     <= hdr_n;
          remaining <= hdr_n;
          idx       <= '0;
          if (hdr_n == 8'd0) begin
            state <= IDLE;
            if (state == DATA || pend_valid) begin
              pend_valid <= 1'b1;
              pend_bx    <= hdr_bx;
            end else begin
              evt_done  <= 1'b1;
              evt_bx    <= hdr_bx;
              evt_nstub <= '0;
            end
          end else begin
            state <= DATA;
          end
        end else if (state == IDLE) begin
          err_orphan <= 1'b1;
        end else begin
          if (idx_full) begin
            err_trunc <= 1'b1;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= {bx[0], idx[IDX_W-1:0]};
            mem_data <= in_data[DATA_W-1:0];
            idx      <= idx + CNT_W'(1);
          end
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
            evt_done  <= 1'b1;
            evt_bx    <= bx;
            evt_nstub <= nstub_sat;
            state     <= IDLE;
          end
        end
      end
    end
  end

endmodule
